// File: rtl/charge_pump_pkg.sv
// Shared types and default parameters for the charge pump sequencer.
package charge_pump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_SKIP      = 3'd3,
    ST_FAULT     = 3'd4
  } cp_state_t;

  typedef enum logic [1:0] {
    PH_P1 = 2'd0,
    PH_D1 = 2'd1,
    PH_P2 = 2'd2,
    PH_D2 = 2'd3
  } cp_phase_t;

  localparam int CP_DEAD_DEF      = 2;
  localparam int CP_SS_CYCLES_DEF = 4;
  localparam int CP_TIMEOUT_DEF   = 64;

endpackage

// File: rtl/cp_sync2.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module cp_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/charge_pump_ctrl.sv
// Two-phase non-overlapping pump clock sequencer with soft-start, pulse-skip
// regulation against a synchronized comparator, and a sticky start-up timeout.
module charge_pump_ctrl
  import charge_pump_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DEAD      = CP_DEAD_DEF,
  parameter int SS_CYCLES = CP_SS_CYCLES_DEF,
  parameter int TIMEOUT   = CP_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             comp_in,
  output logic             phi1,
  output logic             phi2,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int PMAX = (SS_CYCLES > TIMEOUT) ? SS_CYCLES : TIMEOUT;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int DW   = (DEAD > 1) ? $clog2(DEAD) : 1;

  localparam logic [DW-1:0]    DEAD_M1 = DW'(DEAD - 1);
  localparam logic [DW-1:0]    D_ONE   = 1;
  localparam logic [DIV_W:0]   H_ONE   = 1;
  localparam logic [PW-1:0]    P_ONE   = 1;
  localparam logic [PW-1:0]    SS_END  = PW'(SS_CYCLES);
  localparam logic [PW-1:0]    TMO_END = PW'(TIMEOUT);

  cp_state_t      r_state, w_state_nxt;
  cp_phase_t      r_phase, w_phase_nxt;
  logic [DIV_W:0] r_hcnt,  w_hcnt_nxt;
  logic [DIV_W:0] r_hp_m1, w_hp_m1_nxt;
  logic [DW-1:0]  r_dcnt,  w_dcnt_nxt;
  logic [PW-1:0]  r_per,   w_per_nxt;
  logic           r_phi1,  w_phi1_nxt;
  logic           r_phi2,  w_phi2_nxt;
  logic           r_ready, w_ready_nxt;
  logic           r_fault, w_fault_nxt;

  logic           w_comp_s;
  logic           w_active;
  logic           w_in_half;
  logic           w_phase_done;
  logic           w_counting;
  logic [PW-1:0]  w_per_inc;
  logic [DIV_W:0] w_hp_ss_m1;
  logic [DIV_W:0] w_hp_run_m1;

  cp_sync2 u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (w_comp_s)
  );

  // Half-period held as Hp-1 so 2*(div+1) still fits in DIV_W+1 bits.
  assign w_hp_ss_m1  = {div, 1'b1};
  assign w_hp_run_m1 = {1'b0, div};

  assign w_active     = en & ena;
  assign w_in_half    = (r_phase == PH_P1) || (r_phase == PH_P2);
  assign w_phase_done = w_in_half ? (r_hcnt == '0) : (r_dcnt == '0);
  assign w_per_inc    = r_per + P_ONE;
  assign w_counting   = (r_state == ST_RUN) && !r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_hcnt_nxt  = r_hcnt;
    w_hp_m1_nxt = r_hp_m1;
    w_dcnt_nxt  = r_dcnt;
    w_per_nxt   = r_per;
    w_phi1_nxt  = r_phi1;
    w_phi2_nxt  = r_phi2;
    w_ready_nxt = r_ready;
    w_fault_nxt = r_fault;

    if (!w_active) begin
      w_state_nxt = ST_IDLE;
      w_phase_nxt = PH_P1;
      w_hcnt_nxt  = '0;
      w_hp_m1_nxt = '0;
      w_dcnt_nxt  = '0;
      w_per_nxt   = '0;
      w_phi1_nxt  = 1'b0;
      w_phi2_nxt  = 1'b0;
      w_ready_nxt = 1'b0;
      w_fault_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SOFTSTART;
          w_phase_nxt = PH_P1;
          w_hp_m1_nxt = w_hp_ss_m1;
          w_hcnt_nxt  = w_hp_ss_m1;
          w_per_nxt   = '0;
          w_phi1_nxt  = 1'b1;
        end
        ST_FAULT: begin
        end
        default: begin
          if (!w_phase_done) begin
            if (w_in_half) w_hcnt_nxt = r_hcnt - H_ONE;
            else           w_dcnt_nxt = r_dcnt - D_ONE;
          end else begin
            unique case (r_phase)
              PH_P1: begin
                w_phase_nxt = PH_D1;
                w_dcnt_nxt  = DEAD_M1;
                w_phi1_nxt  = 1'b0;
              end
              PH_D1: begin
                w_phase_nxt = PH_P2;
                w_hcnt_nxt  = r_hp_m1;
                w_phi2_nxt  = (r_state != ST_SKIP);
              end
              PH_P2: begin
                w_phase_nxt = PH_D2;
                w_dcnt_nxt  = DEAD_M1;
                w_phi2_nxt  = 1'b0;
              end
              default: begin
                // End of a full period: soft-start bookkeeping or a regulation decision.
                w_phase_nxt = PH_P1;
                if (r_state == ST_SOFTSTART) begin
                  w_per_nxt = w_per_inc;
                  if (w_per_inc == TMO_END) begin
                    w_state_nxt = ST_FAULT;
                    w_fault_nxt = 1'b1;
                    w_ready_nxt = 1'b0;
                  end else if (w_per_inc == SS_END) begin
                    w_state_nxt = ST_RUN;
                    w_hp_m1_nxt = w_hp_run_m1;
                    w_hcnt_nxt  = w_hp_run_m1;
                    w_phi1_nxt  = 1'b1;
                  end else begin
                    w_hp_m1_nxt = w_hp_ss_m1;
                    w_hcnt_nxt  = w_hp_ss_m1;
                    w_phi1_nxt  = 1'b1;
                  end
                end else if (w_comp_s) begin
                  w_state_nxt = ST_SKIP;
                  w_ready_nxt = 1'b1;
                  w_hcnt_nxt  = r_hp_m1;
                end else if (w_counting && (w_per_inc == TMO_END)) begin
                  w_state_nxt = ST_FAULT;
                  w_per_nxt   = w_per_inc;
                  w_fault_nxt = 1'b1;
                  w_ready_nxt = 1'b0;
                end else begin
                  if (w_counting) w_per_nxt = w_per_inc;
                  w_state_nxt = ST_RUN;
                  w_hp_m1_nxt = w_hp_run_m1;
                  w_hcnt_nxt  = w_hp_run_m1;
                  w_phi1_nxt  = 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= PH_P1;
      r_hcnt  <= '0;
      r_hp_m1 <= '0;
      r_dcnt  <= '0;
      r_per   <= '0;
      r_phi1  <= 1'b0;
      r_phi2  <= 1'b0;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_hp_m1 <= w_hp_m1_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_per   <= w_per_nxt;
      r_phi1  <= w_phi1_nxt;
      r_phi2  <= w_phi2_nxt;
      r_ready <= w_ready_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign phi1  = r_phi1;
  assign phi2  = r_phi2;
  assign ready = r_ready;
  assign fault = r_fault;
  assign state = r_state;

endmodule

// File: tb/tb_charge_pump_ctrl.sv
// Bench for charge_pump_ctrl: directed scenarios plus random traffic, compared
// each cycle against a period-queue reference model.
module tb_charge_pump_ctrl;

  localparam int DIV_W = 8;
  localparam int DEAD  = 2;
  localparam int SS_N  = 4;
  localparam int TMO   = 64;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             comp_in;
  logic             phi1;
  logic             phi2;
  logic             ready;
  logic             fault;
  logic [2:0]       state;

  charge_pump_ctrl #(
    .DIV_W     (DIV_W),
    .DEAD      (DEAD),
    .SS_CYCLES (SS_N),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .en      (en),
    .div     (div),
    .comp_in (comp_in),
    .phi1    (phi1),
    .phi2    (phi2),
    .ready   (ready),
    .fault   (fault),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each period is expanded into a queue of per-clock phase
  // values; when the queue runs dry the period has ended and a decision is made.
  int       m_st;
  int       m_cnt;
  int       m_hp;
  bit       m_p1, m_p2, m_rdy, m_flt;
  bit       m_s1, m_s2;
  bit [1:0] m_q[$];

  function automatic void fill(input int hp, input bit live);
    for (int i = 0; i < hp; i++)   m_q.push_back(live ? 2'b10 : 2'b00);
    for (int i = 0; i < DEAD; i++) m_q.push_back(2'b00);
    for (int i = 0; i < hp; i++)   m_q.push_back(live ? 2'b01 : 2'b00);
    for (int i = 0; i < DEAD; i++) m_q.push_back(2'b00);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_hp = 1;
      m_p1 = 0; m_p2 = 0; m_rdy = 0; m_flt = 0;
      m_s1 = 0; m_s2 = 0;
      m_q.delete();
    end else begin
      bit       cs;
      bit [1:0] ph;
      cs   = m_s2;
      m_s2 = m_s1;
      m_s1 = comp_in;
      if (!(en && ena)) begin
        m_st = 0; m_cnt = 0; m_rdy = 0; m_flt = 0;
        m_q.delete();
      end else if (m_st == 0) begin
        m_st = 1; m_cnt = 0;
        fill(2 * (int'(div) + 1), 1'b1);
      end else if (m_st != 4 && m_q.size() == 0) begin
        if (m_st == 1) begin
          m_cnt++;
          if (m_cnt == TMO) begin
            m_st = 4; m_flt = 1; m_rdy = 0;
          end else if (m_cnt == SS_N) begin
            m_st = 2; m_hp = int'(div) + 1; fill(m_hp, 1'b1);
          end else begin
            fill(2 * (int'(div) + 1), 1'b1);
          end
        end else if (cs) begin
          m_st = 3; m_rdy = 1; fill(m_hp, 1'b0);
        end else begin
          if (m_st == 2 && !m_rdy) m_cnt++;
          if (!m_rdy && m_cnt == TMO) begin
            m_st = 4; m_flt = 1;
          end else begin
            m_st = 2; m_hp = int'(div) + 1; fill(m_hp, 1'b1);
          end
        end
      end
      if (m_st >= 1 && m_st <= 3 && m_q.size() > 0) begin
        ph   = m_q.pop_front();
        m_p1 = ph[1];
        m_p2 = ph[0];
      end else begin
        m_p1 = 0;
        m_p2 = 0;
      end
    end
  end

  int gap1 = 1000;
  int gap2 = 1000;
  bit pv1  = 0;
  bit pv2  = 0;

  always @(negedge clk) begin
    chk("outs", 32'({phi1, phi2, ready, fault, state}),
                32'({m_p1, m_p2, m_rdy, m_flt, 3'(m_st)}));
    chk("overlap", 32'(phi1 & phi2), 32'd0);
    if (phi2 && !pv2) chk("gap_phi1_to_phi2", 32'(gap1 >= DEAD), 32'd1);
    if (phi1 && !pv1) chk("gap_phi2_to_phi1", 32'(gap2 >= DEAD), 32'd1);
    gap1 = phi1 ? 0 : ((gap1 < 1000) ? gap1 + 1 : gap1);
    gap2 = phi2 ? 0 : ((gap2 < 1000) ? gap2 + 1 : gap2);
    pv1  = phi1;
    pv2  = phi2;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 0; en = 0; ena = 1; div = 3; comp_in = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);

    // Reset asserted in the middle of P1.
    en = 1;
    cyc(3);
    chk("pre_reset_phi1", 32'(phi1), 32'd1);
    #2 rst_n = 0;
    #1 chk("arst_outs", 32'({phi1, phi2, ready, fault, state}), 32'd0);
    en = 0;
    cyc(2);
    rst_n = 1;
    cyc(3);
    chk("post_reset_outs", 32'({phi1, phi2, ready, fault, state}), 32'd0);

    // Start-up with div=3: 20-clock soft-start periods, then 12-clock RUN.
    en = 1;
    cyc(1);
    chk("en_latency_phi1", 32'(phi1), 32'd1);
    chk("en_state", 32'(state), 32'd1);
    cyc(8);
    chk("ss_p1_len", 32'({phi1, phi2}), 32'd0);
    cyc(2);
    chk("ss_p2_start", 32'(phi2), 32'd1);
    cyc(70);
    chk("run_entry", 32'({phi1, state}), 32'({1'b1, 3'd2}));
    cyc(4);
    chk("run_p1_len", 32'(phi1), 32'd0);
    cyc(8);
    chk("run_period", 32'(phi1), 32'd1);

    // Regulation: comparator high causes skip slots; dropping it resumes RUN.
    comp_in = 1;
    cyc(12);
    chk("ready_set", 32'({ready, state}), 32'({1'b1, 3'd3}));
    cyc(24);
    chk("skip_low", 32'({phi1, phi2}), 32'd0);
    comp_in = 0;
    cyc(12);
    chk("resume_run", 32'({phi1, ready, state}), 32'({1'b1, 1'b1, 3'd2}));

    // Start-up timeout.
    en = 0;
    cyc(2);
    en = 1;
    cyc(1);
    chk("fault_restart", 32'(state), 32'd1);
    cyc(799);
    chk("fault_not_yet", 32'(fault), 32'd0);
    cyc(1);
    chk("fault_set", 32'({fault, state}), 32'({1'b1, 3'd4}));
    cyc(5);
    chk("fault_sticky", 32'({phi1, phi2, fault, state}), 32'({1'b0, 1'b0, 1'b1, 3'd4}));
    en = 0;
    cyc(1);
    chk("fault_clear", 32'({fault, state}), 32'd0);
    en = 1;
    cyc(1);
    chk("fresh_ss", 32'({phi1, state}), 32'({1'b1, 3'd1}));

    // Abort during P2 with div=255.
    en = 0;
    cyc(2);
    div = 8'd255;
    en = 1;
    cyc(1);
    cyc(514);
    chk("abort_in_p2", 32'(phi2), 32'd1);
    en = 0;
    cyc(1);
    chk("abort_drop", 32'({phi2, state}), 32'd0);
    cyc(1);
    en = 1;
    cyc(1);
    chk("abort_reenable", 32'({phi1, state}), 32'({1'b1, 3'd1}));

    // div=0 edge, then div change mid-period.
    en = 0;
    cyc(2);
    div = 8'd0;
    en = 1;
    cyc(1);
    cyc(32);
    chk("div0_run", 32'({phi1, state}), 32'({1'b1, 3'd2}));
    cyc(1);
    chk("div0_p1", 32'(phi1), 32'd0);
    cyc(2);
    chk("div0_p2", 32'(phi2), 32'd1);
    cyc(1);
    chk("div0_p2_end", 32'(phi2), 32'd0);
    cyc(5);
    div = 8'd255;
    cyc(1100);

    // Randomized traffic.
    en = 0;
    div = 8'd2;
    cyc(3);
    en = 1;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        en = 0;
        cyc(int'($urandom_range(2, 4)));
        en = 1;
      end else if (r < 6) begin
        ena = 0;
        cyc(2);
        ena = 1;
      end
      if ($urandom_range(0, 29) == 0) comp_in = ~comp_in;
      if ($urandom_range(0, 99) == 0) div = 8'($urandom_range(0, 5));
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/charge_pump_ctrl.md
# charge_pump_ctrl

Digital sequencer for the on-chip charge pump. It generates the non-overlapping two-phase pump clocks `phi1`/`phi2` with a programmable half-period and a fixed dead time. It soft-starts the pump, then regulates it by pulse-skipping against an external comparator, and flags a fault if the output never reaches its target. It sits between the Tiny Tapeout digital pins and the analog pump switches.

## Interface
- `DIV_W`, 8: width of the half-period divider input.
- `DEAD`, 2: dead-time clocks between phases; must be ≥1.
- `SS_CYCLES`, 4: number of soft-start pump periods.
- `TIMEOUT`, 64: non-skipped pump periods allowed without the comparator going high; must be ≥1.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset. One clock; reset is asynchronous and active-low.
- `ena  in  1`: design powered; `ena=0` is treated exactly as `en=0`.
- `en  in  1`: pump enable.
- `div  in  DIV_W`: half-period select; H = div+1 clocks.
- `comp_in  in  1`: asynchronous comparator output; 1 means Vout is above target.
- `phi1  out  1`: pump phase 1.
- `phi2  out  1`: pump phase 2.
- `ready  out  1`: regulation achieved.
- `fault  out  1`: start-up timeout; sticky.
- `state  out  3`: current FSM state, for debug.

## Operation
- `comp_in` passes through a 2-flop synchronizer to produce `comp_s`, adding 2 clocks of latency.
- FSM states: IDLE=0, SOFTSTART=1, RUN=2, SKIP=3, FAULT=4.
- Phase sub-sequencer runs P1 (`phi1`=1) → D1 → P2 (`phi2`=1) → D2 → P1.
  - P1 and P2 each last Hp clocks; D1 and D2 each last DEAD clocks.
  - Hp = 2·(div+1) in SOFTSTART and div+1 in RUN. Compute it at DIV_W+1 bits, with no overflow.
  - `div` is sampled at the start of each P1 and held for the whole period.
- IDLE → SOFTSTART on the first edge that samples en=1 && ena=1. That same edge begins P1, so `phi1`=1.
- SOFTSTART → RUN after SS_CYCLES complete periods, at the end of D2.
- RUN: at the end of each D2, sample `comp_s`.
  - If 1, go to SKIP: both phases low for one full slot of 2Hp+2DEAD clocks, then re-sample.
  - If 0, go to (or stay in) RUN and start P1.
- SKIP does not consume the timeout budget.
- `ready` sets on the first `comp_s`=1 sample at a RUN/SKIP decision point. It clears only on IDLE or FAULT.
- Timeout counter:
  - Counts completed non-skipped periods, including soft-start periods, while `ready`=0.
  - When it reaches TIMEOUT, go to FAULT: `phi1`=`phi2`=0, `fault`=1.
  - FAULT is left only to IDLE, when en=0 or ena=0 is sampled.
- en=0 or ena=0 in any state → IDLE on that edge.
  - Both phases go low immediately; a phase is never completed.
  - All counters clear and `ready` clears; `fault` clears on entry to IDLE.
- Invariant: `phi1` && `phi2` is never 1.
  - After any `phi1` fall, `phi2` may rise only after ≥DEAD low clocks, and vice versa.
  - This holds across RUN/SKIP/SOFTSTART transitions and when `div` changes.

## Timing
- All outputs are registered. Reset values: `phi1`=0, `phi2`=0, `ready`=0, `fault`=0, `state`=IDLE.
- Enable latency: `phi1` goes high on the same edge that first samples en=1.
- Disable latency: the phases drop on the same edge that samples en=0.
- Comparator latency: a `comp_in` change takes 2 clocks to reach `comp_s`. It acts only at the next D2 end, at most 2Hp+2DEAD+2 clocks later.
- Pump period is 2Hp+2DEAD. Example: div=3, DEAD=2 gives 12 clocks in RUN and 20 in SOFTSTART.
- div=0 gives Hp=1 in RUN and 2 in SOFTSTART. div=all-ones gives Hp=2^DIV_W, with no wrap.
- en=1 while in FAULT stays in FAULT. Re-enabling needs at least one cycle of en=0.

## Structure
- `charge_pump_pkg` holds:
  - state enum `cp_state_t` (IDLE..FAULT);
  - phase enum `cp_phase_t` (P1, D1, P2, D2);
  - default localparams for DEAD, SS_CYCLES and TIMEOUT.
- Sub-module `cp_sync2`: generic 2-flop synchronizer with async active-low reset to 0, used for `comp_in`.
- Top level: FSM, phase sequencer, half-period counter (DIV_W+1 bits), dead counter, period counter (clog2 of max(SS_CYCLES, TIMEOUT)+1 bits).

## Test plan
All scenarios use DIV_W=8, DEAD=2, SS_CYCLES=4, TIMEOUT=64, and check `!(phi1&&phi2)` plus the dead-gap property on every cycle.
- Reset: assert rst_n=0 mid-P1 → all outputs 0 and state=IDLE asynchronously. Release with en=0 → all outputs remain 0.
- Start-up: en=1, div=3, comp_in=0 → 4 periods of 20 clocks (`phi1` high 8, low 2, `phi2` high 8, low 2), then RUN periods of 12 clocks (phases high 4 clocks each).
- Regulation: in RUN, raise comp_in and hold it → at the next D2 end `ready`=1 and the phases stay low in 12-clock skip slots. Drop comp_in → P1 resumes at a slot boundary; `ready` stays 1.
- Fault: comp_in held at 0 → `fault`=1 and the phases stop after the 64th completed period. en=0 → IDLE with `fault`=0. en=1 → fresh soft-start.
- Abort: drop en in P2 with div=255 → `phi2`=0 on the sampling edge and state=IDLE. Re-enable two clocks later → `phi1` rises immediately, i.e. ≥2 clocks after `phi2` fell.
- Edge: div=0 → RUN period of 6 clocks (1/2/1/2). Change div from 0 to 255 mid-period → the new Hp=256 applies from the next P1 only.
